// File: rtl/mem_request_handler_pkg.sv
// Shared constants, state codes and bus payload type for the memory request handler.
package mem_request_handler_pkg;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SEL_W   = 4;
  localparam int unsigned STATE_W = 3;
  localparam int unsigned TIMER_W = 8;

  // FSM state codes
  localparam logic [STATE_W-1:0] ST_FETCH = 3'd0;
  localparam logic [STATE_W-1:0] ST_CHECK = 3'd1;
  localparam logic [STATE_W-1:0] ST_DATA  = 3'd2;
  localparam logic [STATE_W-1:0] ST_EXEC  = 3'd3;
  localparam logic [STATE_W-1:0] ST_ERROR = 3'd4;

  // addi x0,x0,0
  localparam logic [XLEN-1:0]  NOP_INSTR = 32'h0000_0013;
  localparam logic [SEL_W-1:0] SEL_WORD  = 4'hF;

  // One memory-bus request as driven towards the external interface
  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  wdata;
    logic [SEL_W-1:0] sel;
    logic             read;
    logic             write;
  } bus_req_t;

  // States in which a bus request is outstanding and the watchdog runs
  function automatic logic is_bus_state(input logic [STATE_W-1:0] st);
    return (st == ST_FETCH) || (st == ST_DATA);
  endfunction

endpackage

// File: rtl/mem_request_handler_access_timer.sv
// Access watchdog: counts wait cycles of one bus request and flags the last allowed cycle.
module mem_request_handler_access_timer
  import mem_request_handler_pkg::*;
#(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(LIMIT - 1);

  logic [TIMER_W-1:0] count_q;
  logic [TIMER_W-1:0] count_d;
  logic               expired_q;

  // Next count: clear wins over enable
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + TIMER_W'(1);
    end
  end

  // Counter register; expired is registered so it is high while count_q sits at the limit
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      expired_q <= (count_d == LAST);
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/mem_request_handler.sv
// Sequences instruction fetch and data access of a single-cycle core over one shared bus.
module mem_request_handler
  import mem_request_handler_pkg::*;
#(
  parameter int unsigned     TIMEOUT     = 16,
  parameter logic [XLEN-1:0] RESET_INSTR = NOP_INSTR
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic [XLEN-1:0]   pc,
  input  logic              dmm_read,
  input  logic              dmm_write,
  input  logic [XLEN-1:0]   dmm_addr,
  input  logic [XLEN-1:0]   dmm_wdata,
  input  logic [SEL_W-1:0]  dmm_sel,
  output logic [XLEN-1:0]   instruction,
  output logic [XLEN-1:0]   memload,
  output logic              freeze,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [SEL_W-1:0]  bus_sel,
  output logic              bus_read,
  output logic              bus_write,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_ack,
  output logic              bus_error
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  logic [XLEN-1:0]    instruction_q;
  logic [XLEN-1:0]    instruction_d;
  logic [XLEN-1:0]    memload_q;
  logic [XLEN-1:0]    memload_d;
  logic               pc_aligned;
  logic               timer_en;
  logic               timer_expired;
  bus_req_t           req;

  assign pc_aligned = (pc[1:0] == 2'b00);

  // Watchdog runs only while waiting for an ack; any other cycle restarts it
  assign timer_en = is_bus_state(state_q) && !bus_ack;

  mem_request_handler_access_timer #(
    .LIMIT (TIMEOUT)
  ) u_timer (
    .clk_i     (clk),
    .rst_ni    (nrst),
    .clear_i   (!timer_en),
    .en_i      (timer_en),
    .expired_o (timer_expired)
  );

  // Next-state, instruction and load-data latch decisions
  always_comb begin
    state_d       = state_q;
    instruction_d = instruction_q;
    memload_d     = memload_q;
    case (state_q)
      ST_FETCH: begin
        if (!pc_aligned) begin
          state_d = ST_ERROR;
        end else if (bus_ack) begin
          instruction_d = bus_rdata;
          state_d       = ST_CHECK;
        end else if (timer_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_CHECK: begin
        if (dmm_read && dmm_write) begin
          state_d = ST_ERROR;
        end else if (dmm_read || dmm_write) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_DATA: begin
        if (bus_ack) begin
          if (dmm_read) begin
            memload_d = bus_rdata;
          end
          state_d = ST_EXEC;
        end else if (timer_expired) begin
          state_d = ST_ERROR;
        end
      end
      ST_EXEC:  state_d = ST_FETCH;
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ERROR;
    endcase
  end

  // State and latched core-facing data
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_FETCH;
      instruction_q <= RESET_INSTR;
      memload_q     <= '0;
    end else begin
      state_q       <= state_d;
      instruction_q <= instruction_d;
      memload_q     <= memload_d;
    end
  end

  // Bus request decode; strobes drop as soon as reset is asserted
  always_comb begin
    req = '0;
    case (state_q)
      ST_FETCH: begin
        req.addr = pc;
        req.sel  = SEL_WORD;
        req.read = pc_aligned;
      end
      ST_DATA: begin
        req.addr  = dmm_addr;
        req.wdata = dmm_wdata;
        req.sel   = dmm_sel;
        req.read  = dmm_read;
        req.write = dmm_write;
      end
      default: ;
    endcase
    if (!nrst) begin
      req.read  = 1'b0;
      req.write = 1'b0;
    end
  end

  assign bus_addr    = req.addr;
  assign bus_wdata   = req.wdata;
  assign bus_sel     = req.sel;
  assign bus_read    = req.read;
  assign bus_write   = req.write;
  assign instruction = instruction_q;
  assign memload     = memload_q;
  assign freeze      = (state_q != ST_EXEC);
  assign bus_error   = (state_q == ST_ERROR);

endmodule

// File: doc/mem_request_handler.md
Name: mem_request_handler

Overview:
- Sequences the single-cycle core's instruction fetch and data load/store over one shared memory bus.
- Fetches the word at pc, holds it as the core's instruction, and runs the data access if the core's decoded op needs one.
- Releases the core for exactly one execute cycle per instruction; the core's freeze input gates PC and register-file writes.
- Sits between the core top and the external memory/bus interface; includes an access timeout watchdog.

Parameters:
- TIMEOUT, 16, max cycles a bus request may wait for ack before entering ERROR (legal range 2..255).
- RESET_INSTR, 32'h00000013, instruction value presented while no fetch has completed (NOP: addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- pc  in  32  core program counter; fetch address.
- dmm_read  in  1  core decoded op is a load (valid while instruction is stable).
- dmm_write  in  1  core decoded op is a store.
- dmm_addr  in  32  data address from the ALU.
- dmm_wdata  in  32  store data.
- dmm_sel  in  4  byte enables for the data access.
- instruction  out  32  latched instruction to the core.
- memload  out  32  latched load data to the core.
- freeze  out  1  1 = core must hold PC/regfile; 0 = execute cycle.
- bus_addr  out  32  memory address.
- bus_wdata  out  32  memory write data.
- bus_sel  out  4  byte enables (4'hF on fetch).
- bus_read  out  1  read request, held until ack.
- bus_write  out  1  write request, held until ack.
- bus_rdata  in  32  read data, valid in the cycle bus_ack=1.
- bus_ack  in  1  one-cycle completion strobe.
- bus_error  out  1  sticky error flag.

Behaviour:
- Reset (async, nrst=0): state=FETCH, instruction=RESET_INSTR, memload=0, freeze=1, bus_error=0, timeout counter=0. Bus outputs follow the FETCH state (bus_read=1 resumes on the first cycle after release).
- States and transitions:
  - FETCH: bus_read=1, bus_addr=pc, bus_sel=4'hF, bus_write=0, freeze=1. On bus_ack: instruction<=bus_rdata, go to CHECK.
  - CHECK: no bus request, freeze=1; one cycle for the core's decode to settle.
    - dmm_read & dmm_write -> ERROR.
    - dmm_read | dmm_write -> DATA.
    - otherwise -> EXEC.
  - DATA: bus_addr=dmm_addr, bus_sel=dmm_sel, bus_read=dmm_read, bus_write=dmm_write, bus_wdata=dmm_wdata, freeze=1. On bus_ack: if read, memload<=bus_rdata; go to EXEC.
  - EXEC: freeze=0 for exactly one cycle, no bus request, then FETCH. The core commits on the EXEC rising edge and pc changes after it.
  - ERROR: all bus requests 0, freeze=1, bus_error=1. Absorbing; exit only via nrst.
- Misaligned fetch (pc[1:0]!=0) in FETCH: go to ERROR without asserting bus_read for that request.
- Timeout counter:
  - Cleared on entry to FETCH/DATA; increments each FETCH/DATA cycle without ack.
  - When it reaches TIMEOUT-1 with no ack, go to ERROR next edge.
  - An ack in the same cycle as the limit wins and completes normally.
- bus_ack outside FETCH/DATA is ignored; no latch occurs.
- A store does not modify memload; memload holds the last load value.
- Minimum latency per instruction: ack-in-first-cycle gives FETCH(1)+CHECK(1)+EXEC(1)=3 cycles, or 4 cycles with a data access.
- Request signals are registered-state decodes. bus_addr/wdata/sel follow the core inputs combinationally in DATA; the core holds them stable because freeze=1.
- Reset asserted mid-access drops bus_read/bus_write immediately (async). The bus must tolerate an abandoned request.

Decomposition:
- Shared package: state enum (FETCH, CHECK, DATA, EXEC, ERROR), RESET_INSTR/NOP constant, SEL_WORD=4'hF.
- One sub-module: access_timer (counter with clear/enable/limit -> expired). The FSM and latches stay in mem_request_handler.

Test Plan:
- ADDI fetch: pc=0, memory returns 32'h3e800093 with ack after 2 wait cycles -> instruction=32'h3e800093, freeze low exactly once, 0 bus_write, next fetch at pc=4.
- Load: fetched instr with dmm_read=1, dmm_addr=32'h100, bus_rdata=32'hDEADBEEF -> bus_read at addr 0x100, memload=32'hDEADBEEF before the EXEC cycle.
- Store: dmm_write=1, dmm_addr=0x104, dmm_wdata=0x12345678, dmm_sel=4'b0011 -> bus_write with those values held until ack, memload unchanged.
- Timeout: TIMEOUT=16, no ack in FETCH -> bus_error=1 after 16 cycles, bus_read=0, freeze stays 1 until nrst.
- Illegal combinations: pc=32'h2 -> ERROR with no bus_read; dmm_read=dmm_write=1 in CHECK -> ERROR.
- Async reset mid-DATA: nrst=0 while bus_write=1 -> bus_write=0, freeze=1, instruction=32'h00000013 immediately, without waiting for a clock edge.
